// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shift-mode encodings shared by the shifter pipeline and its bus interface.
package shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_op_t;
endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: valid/ready operand and result channels of the barrel shifter; out_zero exists only with SHIFT_FLAGS_EN.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  import shift_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  shift_op_t        in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFT_FLAGS_EN
  logic             out_zero;
  modport master (output in_valid, in_data, in_amt, in_op, out_ready,
                  input  in_ready, out_valid, out_data, out_zero);
  modport slave  (input  in_valid, in_data, in_amt, in_op, out_ready,
                  output in_ready, out_valid, out_data, out_zero);
`else
  modport master (output in_valid, in_data, in_amt, in_op, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_amt, in_op, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/shift_pipe_stage.sv
// shift_stage: one pipeline slice that shifts by 2^K when its amount bit is set, then registers the beat.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  shift_op_t        src_op,
  input  logic             src_sgn,
  input  logic [SHW-1:0]   src_amt,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output shift_op_t        op,
  output logic             sgn,
  output logic [SHW-1:0]   amt
);
  localparam int S = 1 << K;
  logic [WIDTH-1:0] srl, res;
  // SRA fills from the sign captured at entry, not from this stage's MSB
  always_comb begin
    srl = src_data >> S;
    res = !src_amt[K]           ? src_data :
          src_op == SHIFT_SLL   ? src_data << S :
          src_op == SHIFT_SRL   ? srl :
          src_op == SHIFT_SRA   ? srl | ({WIDTH{src_sgn}} & ~({WIDTH{1'b1}} >> S)) :
                                  srl | (src_data << (WIDTH - S));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      op    <= SHIFT_SLL;
      sgn   <= 1'b0;
      amt   <= '0;
    end else if (adv) begin
      valid <= src_valid;
      data  <= res;
      op    <= src_op;
      sgn   <= src_sgn;
      amt   <= src_amt;
    end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: SHW-stage pipelined barrel shifter (SLL/SRL/SRA/ROR), MSB stage first; SHIFT_FLAGS_EN adds out_zero.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst,
  shift_pipe_if.slave bus
);
  logic             adv;
  logic [SHW:0]     v;
  logic [SHW:0]     s;
  logic [WIDTH-1:0] d [SHW+1];
  shift_op_t        o [SHW+1];
  logic [SHW-1:0]   a [SHW+1];
  logic             unused;
  // whole pipe moves as one; a stalled output freezes every stage, bubbles included
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  assign v[SHW]       = bus.in_valid;
  assign d[SHW]       = bus.in_data;
  assign o[SHW]       = bus.in_op;
  assign s[SHW]       = bus.in_data[WIDTH-1];
  assign a[SHW]       = bus.in_amt;
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .K(k), .SHW(SHW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .src_valid (v[k+1]),
      .src_data  (d[k+1]),
      .src_op    (o[k+1]),
      .src_sgn   (s[k+1]),
      .src_amt   (a[k+1]),
      .valid     (v[k]),
      .data      (d[k]),
      .op        (o[k]),
      .sgn       (s[k]),
      .amt       (a[k])
    );
  end
  assign bus.out_valid = v[0];
  assign bus.out_data  = d[0];
`ifdef SHIFT_FLAGS_EN
  assign bus.out_zero  = v[0] & ~|d[0];
`endif
  assign unused = ^{o[0], s[0], a[0]};
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed table plus stall, back-to-back and mid-stream reset sequences for shift_pipe (WIDTH=32).
module tb_shift_pipe;
  import shift_pkg::*;
  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    shift_op_t   o;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [14];
  shift_pipe_if #(.WIDTH(32)) bus ();
  shift_pipe #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run_one(input logic [31:0] d, input logic [4:0] a, input shift_op_t o,
                         output logic [31:0] res, output int lat, output logic z);
    logic got;
    @(negedge clk);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_op     = o;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    res = 'x;
    z   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin
        got = 1'b1;
        res = bus.out_data;
`ifdef SHIFT_FLAGS_EN
        z = bus.out_zero;
`endif
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] res;
    int lat, rx;
    logic z;
    vecs[0]  = '{32'hF000_000F, 5'd16, SHIFT_SRL, 32'h0000_F000};
    vecs[1]  = '{32'h8000_0000, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000};
    vecs[3]  = '{32'h0000_0001, 5'd1,  SHIFT_ROR, 32'h8000_0000};
    vecs[4]  = '{32'hA5A5_1234, 5'd0,  SHIFT_SLL, 32'hA5A5_1234};
    vecs[5]  = '{32'hA5A5_1234, 5'd0,  SHIFT_SRL, 32'hA5A5_1234};
    vecs[6]  = '{32'hA5A5_1234, 5'd0,  SHIFT_SRA, 32'hA5A5_1234};
    vecs[7]  = '{32'hA5A5_1234, 5'd0,  SHIFT_ROR, 32'hA5A5_1234};
    vecs[8]  = '{32'h7FFF_0000, 5'd4,  SHIFT_SRA, 32'h07FF_F000};
    vecs[9]  = '{32'hF000_0000, 5'd4,  SHIFT_SRA, 32'hFF00_0000};
    vecs[10] = '{32'h1234_5678, 5'd8,  SHIFT_ROR, 32'h7812_3456};
    vecs[11] = '{32'h0000_0001, 5'd1,  SHIFT_SRL, 32'h0000_0000};
    vecs[12] = '{32'h0000_ABCD, 5'd20, SHIFT_SLL, 32'hBCD0_0000};
    vecs[13] = '{32'h8000_0001, 5'd31, SHIFT_ROR, 32'h0000_0003};
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = SHIFT_SLL;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
`ifdef SHIFT_FLAGS_EN
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    foreach (vecs[i]) begin
      run_one(vecs[i].d, vecs[i].a, vecs[i].o, res, lat, z);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
`ifdef SHIFT_FLAGS_EN
      chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp == 32'd0));
`endif
    end
    // back-to-back: 32 beats of 1<<n must stream out with no gaps
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("b2b_valid_c%0d", c), 32'(bus.out_valid), 32'(c >= 5 && c < 37));
      if (c >= 5 && c < 37 && bus.out_valid)
        chk($sformatf("b2b_data_%0d", c - 5), bus.out_data, 32'h1 << (c - 5));
      bus.in_valid = (c < 32);
      bus.in_data  = 32'h1;
      bus.in_amt   = 5'(c);
      bus.in_op    = SHIFT_SLL;
      @(negedge clk);
    end
    // stall: fill the pipe with out_ready low, hold 10 cycles, then drain
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC0DE_0000 + 32'(n);
      bus.in_amt   = 5'd0;
      bus.in_op    = SHIFT_SRL;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("stall_out_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall_out_data_%0d", i), bus.out_data, 32'hC0DE_0000);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    rx = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        chk($sformatf("drain_data_%0d", rx), bus.out_data, 32'hC0DE_0000 + 32'(rx));
        rx++;
      end
      @(negedge clk);
    end
    chk("drain_count", 32'(rx), 32'd5);
    // reset with beats in flight
    for (int n = 0; n < 3; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1;
      bus.in_amt   = 5'd3;
      bus.in_op    = SHIFT_SLL;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) rx++;
    end
    chk("midrst_leftover", 32'(rx), 32'd0);
    run_one(32'h0000_00FF, 5'd4, SHIFT_SLL, res, lat, z);
    chk("post_midrst_data", res, 32'h0000_0FF0);
    chk("post_midrst_latency", 32'(lat), 32'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ALU32 datapath.
- Generalises the fixed 16-bit logical-right stage to any power-of-two WIDTH and four shift modes.
- One registered stage per shift-amount bit; stage k conditionally shifts by 2^k, MSB stage first.
- valid/ready handshake on both sides, with full-pipeline backpressure.

Parameters:
- WIDTH, 32, data width in bits; power of two, 4..64.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts input this cycle
- in_data  input  WIDTH  operand
- in_amt  input  SHW  shift amount, 0..WIDTH-1
- in_op  input  2  0=SLL, 1=SRL, 2=SRA, 3=ROR
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  result==0 (only with SHIFT_FLAGS_EN)

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits 0; out_valid=0; out_data=0; out_zero=0.
  - in_ready=1 one cycle after release.
- Pipeline: SHW register stages, S[SHW-1] (shift 2^(SHW-1)) to S[0] (shift 1).
  - Each stage carries valid, data, op and the remaining amount bits.
  - Output register is S[0]; latency is exactly SHW cycles from accept to out_valid.
- Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - All stages load from their predecessor only when adv=1; otherwise every stage holds.
  - A bubble (valid=0) does not collapse while stalled; throughput is 1 beat/cycle when out_ready is held high.
- Input accept: in_valid & in_ready. On accept, S[SHW-1] loads the operand.
  - If in_valid=0 while adv=1, a bubble enters.
- Stage k, amt bit k=1:
  - SLL: d<<2^k, zero fill.
  - SRL: d>>2^k, zero fill.
  - SRA: d>>2^k, fill with the original operand MSB. The sign bit is captured at entry and carried along, not re-read per stage.
  - ROR: rotate right by 2^k.
- Stage k, amt bit k=0: data passes unchanged.
- Amount 0: out_data=in_data for all ops.
- in_amt cannot exceed WIDTH-1, so there is no overflow case.
- Stall: out_data and out_valid hold stable while out_valid=1 & out_ready=0. Values must not change until handshake.
- Simultaneous handshake: accept at input and drain at output occur in the same cycle with no bubble inserted.
- Reset mid-operation: all in-flight beats are discarded; no partial output.
- in_data, in_amt and in_op are don't-care when in_valid=0. Stage data registers may load garbage with valid=0.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- Defined:
  - out_zero = ~|out_data, driven combinationally from the output register. No extra latency.
  - Meaningful only when out_valid=1; held 0 in reset.
- Undefined:
  - out_zero port absent; no reduction logic.

Decomposition:
- Package shift_pkg holds:
  - op encodings SHIFT_SLL=2'd0, SHIFT_SRL=2'd1, SHIFT_SRA=2'd2, SHIFT_ROR=2'd3.
  - typedef shift_op_t.
- Sub-module shift_stage, parameters WIDTH and K:
  - one combinational shift by 2^K plus its registered valid/data/op/sign/amt slice, with the adv enable.
  - shift_pipe instantiates SHW copies via generate.

Test Plan:
- WIDTH=32, SRL, in_data=32'hF000_000F, amt=16 → after 5 cycles out_data=32'h0000_F000, out_valid=1.
- SRA, in_data=32'h8000_0000, amt=31 → out_data=32'hFFFF_FFFF. SLL, in_data=32'h0000_0001, amt=31 → 32'h8000_0000.
- ROR, in_data=32'h0000_0001, amt=1 → 32'h8000_0000. Amount 0 with each op → data unchanged.
- Back-to-back beats with out_ready=1, amt=0..31 ascending on 32'h1 SLL → 32 consecutive results 1<<n; no gaps.
- Hold out_ready=0 for 10 cycles with a full pipe → in_ready=0, out_data stable. Release → 5 queued results in order, none lost or duplicated.
- Assert rst mid-stream with 3 beats in flight → out_valid=0 immediately; after release, the next beat returns correctly. With SHIFT_FLAGS_EN, SRL 32'h1 by 1 → out_zero=1.
